adv_timer_counter: RTL
======================

// Module: adv_timer_counter
// PURPOSE
//  Event-driven prescaled up/down counter for one advanced-timer channel. Sits directly downstream of the timer
//  input stage: consumes its per-cycle event strobe, prescales it and advances a NUM_BITS counter in sawtooth or
//  up/down mode. Produces counter value, direction, advance strobe (for comparators) and period-end pulse
//  (fed back to the input stage as its counter-end input).
// PARAMETERS
//  NUM_BITS    16  counter, start and end width
//  PRESC_BITS  8   prescaler width
// PORTS
//  clk_i           in   1           clock; single clock domain
//  rst_i           in   1           reset, synchronous, active-high
//  ctrl_active_i   in   1           1 = counting enabled; 0 = freeze prescaler/counter
//  ctrl_update_i   in   1           load cfg_* into shadow registers
//  ctrl_rst_i      in   1           restart: counter to start, prescaler cleared, direction up
//  cfg_start_i     in   NUM_BITS    period start value
//  cfg_end_i       in   NUM_BITS    period end value
//  cfg_presc_i     in   PRESC_BITS  events per tick minus 1 (0 = every event ticks)
//  cfg_sawtooth_i  in   1           1 = sawtooth, 0 = up/down (triangle)
//  event_i         in   1           event strobe from input stage
//  counter_o       out  NUM_BITS    current count
//  dir_o           out  1           0 = counting up, 1 = counting down
//  tick_o          out  1           registered 1-cycle pulse: counter advanced this cycle
//  end_o           out  1           registered 1-cycle pulse: period completed
// BEHAVIOUR
//  - Reset (rst_i=1 at posedge): counter_o=0, dir_o=0, tick_o=0, end_o=0, prescaler count=0;
//    shadow start=0, end=0, presc=0, sawtooth=1. rst_i overrides all other inputs.
//  - Shadow regs load on ctrl_update_i regardless of ctrl_active_i; new values are used from the next cycle.
//  - tick condition (internal): ctrl_active_i & event_i & (presc_cnt == shadow presc). On tick presc_cnt<=0;
//    on event_i without tick presc_cnt<=presc_cnt+1. presc_cnt never exceeds shadow presc: if presc is lowered
//    below presc_cnt, the next event ticks and clears.
//  - Latency: event_i in cycle n -> counter_o, dir_o, tick_o, end_o updated at posedge ending cycle n; tick_o and
//    end_o are high for exactly that following cycle, else 0.
//  - Sawtooth, on tick: if counter >= end -> counter<=start, end_o=1; else counter<=counter+1. dir_o stays 0.
//  - Up/down, state UP (dir_o=0), on tick: if counter >= end -> if end > start: dir<=DOWN, counter<=end-1;
//    else (end <= start): counter<=start, end_o=1, stay UP. Else counter<=counter+1.
//  - Up/down, state DOWN (dir_o=1), on tick: if counter <= start -> dir<=UP, counter<=start+1 (start if
//    start >= end), end_o=1. Else counter<=counter-1.
//  - Arithmetic modulo 2^NUM_BITS; >= / <= comparisons unsigned, so a counter left above a newly lowered end
//    reloads on the next tick, never wrapping through zero.
//  - ctrl_rst_i (priority over tick): counter<=start (cfg_start_i if ctrl_update_i same cycle), presc_cnt<=0,
//    dir<=UP, tick_o=0, end_o=0. Allowed while inactive.
//  - ctrl_active_i=0: counter, dir, presc_cnt hold; event_i ignored; tick_o=end_o=0.
//  - Switching mode mid-period: takes effect on next tick from current counter/dir; sawtooth forces dir<=UP on
//    its first tick.
// TESTING
//  1 Sawtooth start=2 end=5 presc=0, event_i every cycle: counter 2,3,4,5,2...; end_o on each 5->2 edge;
//    tick_o continuous.
//  2 Up/down start=0 end=3 presc=0: counter 0,1,2,3,2,1,0,1...; dir_o 1 from the 2 after 3 through 0;
//    end_o once per 6 ticks, at 0->1.
//  3 presc=2, event_i every cycle: counter advances every 3rd cycle; tick_o 1-in-3; events while
//    ctrl_active_i=0 do not advance presc_cnt.
//  4 Count at 9 (end=10), ctrl_update_i to end=4: next tick -> counter=start, end_o=1; ctrl_rst_i with tick
//    same cycle -> counter=start, tick_o=end_o=0.
//  5 start=end=7 both modes: every tick -> counter=7, end_o=1, dir_o=0; NUM_BITS all-ones end wraps to start,
//    no zero crossing.
//  6 rst_i mid-count (counter=3, dir=1): next cycle all outputs 0, shadow regs default, sawtooth=1.

Source files
------------

// File: rtl/adv_timer_counter.sv
`default_nettype none
// ============================================================================
//  Module      : adv_timer_counter
//  Description : Event-driven prescaled counter for one advanced-timer channel.
//                Supports sawtooth and up/down (triangle) counting, shadowed
//                configuration, advance strobe and period-end pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module adv_timer_counter #(
  parameter int NUM_BITS   = 16,
  parameter int PRESC_BITS = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ctrl_active_i,
  input  logic                  ctrl_update_i,
  input  logic                  ctrl_rst_i,
  input  logic [NUM_BITS-1:0]   cfg_start_i,
  input  logic [NUM_BITS-1:0]   cfg_end_i,
  input  logic [PRESC_BITS-1:0] cfg_presc_i,
  input  logic                  cfg_sawtooth_i,
  input  logic                  event_i,
  output logic [NUM_BITS-1:0]   counter_o,
  output logic                  dir_o,
  output logic                  tick_o,
  output logic                  end_o
);

  localparam logic [NUM_BITS-1:0]   CNT_ONE   = {{(NUM_BITS-1){1'b0}}, 1'b1};
  localparam logic [PRESC_BITS-1:0] PRESC_ONE = {{(PRESC_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Shadow configuration
  logic [NUM_BITS-1:0]   r_start;
  logic [NUM_BITS-1:0]   r_end;
  logic [PRESC_BITS-1:0] r_presc;
  logic                  r_saw;

  // Counting state
  logic [PRESC_BITS-1:0] r_presc_cnt;
  logic [NUM_BITS-1:0]   r_counter;
  dir_t                  r_dir;
  logic                  r_tick;
  logic                  r_end_p;

  // Next-state values
  logic [PRESC_BITS-1:0] w_presc_cnt;
  logic [NUM_BITS-1:0]   w_counter;
  dir_t                  w_dir;
  logic                  w_tick;
  logic                  w_end_p;
  logic                  w_tick_cond;
  logic [NUM_BITS-1:0]   w_restart_val;

  // Shadow registers capture the configuration whenever an update is requested
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_start <= '0;
      r_end   <= '0;
      r_presc <= '0;
      r_saw   <= 1'b1;
    end else if (ctrl_update_i) begin
      r_start <= cfg_start_i;
      r_end   <= cfg_end_i;
      r_presc <= cfg_presc_i;
      r_saw   <= cfg_sawtooth_i;
    end
  end

  // State register for prescaler, counter, direction and output pulses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_presc_cnt <= '0;
      r_counter   <= '0;
      r_dir       <= DIR_UP;
      r_tick      <= 1'b0;
      r_end_p     <= 1'b0;
    end else begin
      r_presc_cnt <= w_presc_cnt;
      r_counter   <= w_counter;
      r_dir       <= w_dir;
      r_tick      <= w_tick;
      r_end_p     <= w_end_p;
    end
  end

  // Next-state logic: restart, prescaling and sawtooth / triangle stepping
  always_comb begin
    w_presc_cnt   = r_presc_cnt;
    w_counter     = r_counter;
    w_dir         = r_dir;
    w_tick        = 1'b0;
    w_end_p       = 1'b0;
    // >= rather than == so a prescaler lowered below the running count ticks at once
    w_tick_cond   = ctrl_active_i & event_i & (r_presc_cnt >= r_presc);
    // A restart issued together with an update uses the incoming start value
    w_restart_val = ctrl_update_i ? cfg_start_i : r_start;

    if (ctrl_rst_i) begin
      w_counter   = w_restart_val;
      w_presc_cnt = '0;
      w_dir       = DIR_UP;
    end else if (ctrl_active_i && event_i) begin
      if (w_tick_cond) begin
        w_presc_cnt = '0;
        w_tick      = 1'b1;
        if (r_saw) begin
          w_dir = DIR_UP;
          if (r_counter >= r_end) begin
            w_counter = r_start;
            w_end_p   = 1'b1;
          end else begin
            w_counter = r_counter + CNT_ONE;
          end
        end else if (r_dir == DIR_UP) begin
          if (r_counter >= r_end) begin
            if (r_end > r_start) begin
              w_dir     = DIR_DOWN;
              w_counter = r_end - CNT_ONE;
            end else begin
              // Degenerate period: behaves like a one-step sawtooth
              w_counter = r_start;
              w_end_p   = 1'b1;
            end
          end else begin
            w_counter = r_counter + CNT_ONE;
          end
        end else begin
          if (r_counter <= r_start) begin
            w_dir     = DIR_UP;
            w_counter = (r_start >= r_end) ? r_start : (r_start + CNT_ONE);
            w_end_p   = 1'b1;
          end else begin
            w_counter = r_counter - CNT_ONE;
          end
        end
      end else begin
        w_presc_cnt = r_presc_cnt + PRESC_ONE;
      end
    end
  end

  assign counter_o = r_counter;
  assign dir_o     = r_dir;
  assign tick_o    = r_tick;
  assign end_o     = r_end_p;

endmodule
`default_nettype wire
